// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- iterative RV32M multiply/divide unit for the execute stage.
//
// Takes one operation per start pulse, works on operand magnitudes one bit per
// cycle (shift-add multiply, restoring divide), then fixes the sign and picks
// the requested half or quotient/remainder in a single DONE cycle.
// Divide-by-zero and signed-overflow cases finish straight from acceptance.
// WIDTH must be even and at least 8.
//
// Ports:
//   clk     clock
//   rst     synchronous active-high reset
//   start   operation request, only looked at while idle
//   op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b    rs1 / rs2 operands, captured together with start
//   flush   abort the in-flight operation (mispredict or trap)
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse; result is valid in that cycle
//   result  operation result; holds its value until the next completion
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;      // final result must be negated
  logic             r_special;  // r_lo already holds the finished result
  logic [WIDTH:0]   r_acc;      // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] r_opb;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_result;

  // Acceptance-time decode of the incoming request.
  op_t              w_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_res_neg;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    w_op          = op_t'(op);
    w_a_neg       = a[WIDTH-1] && (w_op == OP_MUL || w_op == OP_MULH ||
                                   w_op == OP_MULHSU || w_op == OP_DIV ||
                                   w_op == OP_REM);
    w_b_neg       = b[WIDTH-1] && (w_op == OP_MUL || w_op == OP_MULH ||
                                   w_op == OP_DIV || w_op == OP_REM);
    // -MIN_NEG wraps to itself, which is the right magnitude read as unsigned.
    w_a_mag       = w_a_neg ? (~a + WIDTH'(1)) : a;
    w_b_mag       = w_b_neg ? (~b + WIDTH'(1)) : b;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    w_res_neg     = (w_op == OP_REM || w_op == OP_REMU) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_special     = 1'b0;
    w_special_res = '0;
    if (op[2] && b == '0) begin
      w_special     = 1'b1;
      w_special_res = op[1] ? a : '1;
    end else if ((w_op == OP_DIV || w_op == OP_REM) && a == MIN_NEG && b == '1) begin
      w_special     = 1'b1;
      w_special_res = (w_op == OP_DIV) ? MIN_NEG : '0;
    end
  end

  // One iteration step for each algorithm.
  logic [WIDTH:0]   w_sum;    // shift-add partial sum, carry kept in the MSB
  logic [WIDTH:0]   w_shift;  // partial remainder shifted left with next dividend bit
  logic [WIDTH+1:0] w_diff;   // trial subtract; MSB is the borrow

  always_comb begin
    w_sum   = r_acc + {1'b0, r_opb & {WIDTH{r_lo[0]}}};
    w_shift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
  end

  // Sign fix-up and output selection, evaluated in the DONE cycle.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_final;

  always_comb begin
    w_prod     = {r_acc[WIDTH-1:0], r_lo};
    w_prod_fix = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_quo_fix  = r_neg ? (~r_lo + WIDTH'(1)) : r_lo;
    w_rem_fix  = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    case (r_op)
      OP_MUL:                      w_final = w_prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             w_final = w_quo_fix;
      default:                     w_final = w_rem_fix;
    endcase
    if (r_special) w_final = r_lo;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // flush wins over a simultaneous start.
          if (start && !flush) begin
            r_op      <= w_op;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_special <= w_special;
            if (w_special) begin
              r_neg   <= 1'b0;
              r_lo    <= w_special_res;
              r_state <= DONE;
            end else begin
              r_neg   <= w_res_neg;
              // Multiply: r_lo = multiplier (b), r_opb = multiplicand (a).
              // Divide:   r_lo = dividend (a),   r_opb = divisor (b).
              r_lo    <= op[2] ? w_a_mag : w_b_mag;
              r_opb   <= op[2] ? w_b_mag : w_a_mag;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            if (!r_op[2]) begin
              // Add-then-shift-right keeps the product in {r_acc, r_lo}.
              r_acc <= {1'b0, w_sum[WIDTH:1]};
              r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            end else begin
              // Restore by keeping the shifted value when the subtract borrows.
              r_acc <= w_diff[WIDTH+1] ? w_shift : w_diff[WIDTH:0];
              r_lo  <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH+1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (!flush) r_result <= w_final;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // done and result are gated by flush in the same cycle so an aborted
  // operation never signals completion or disturbs the held result.
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE) && !flush;
  assign result = done ? w_final : r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter -- self-checking bench for muldiv_iter (WIDTH=32).
// Directed cases plus random operations compared against an arithmetic
// reference model of the RV32M operations and their expected latency.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_exp;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return MIN_NEG;
        return 32'(int'(x) / int'(y));
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(x) % int'(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycles from acceptance until the done cycle.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o >= 3'd4 && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == MIN_NEG && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return MIN_NEG;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation in the current (idle) cycle and follow it to done.
  // With poke set, a conflicting start is pulsed during the calculation.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit poke);
    logic [31:0] exp_res;
    int          lat;
    int          cyc;
    bit          busy_ok;
    exp_res = model(o, x, y);
    lat     = exp_latency(o, x, y);
    check({tag, " busy@accept"}, busy, 0);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    if (!done) check({tag, " result held"}, result, last_exp);
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      start = poke && cyc >= 3 && cyc <= 6;
      if (start) begin op = ~o; a = $urandom; b = $urandom; end
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " busy in calc"}, busy_ok, 1);
    check({tag, " busy@done"}, busy, 1);
    last_exp = exp_res;
    step();
    check({tag, " done pulse"}, done, 0);
    check({tag, " busy after"}, busy, 0);
    check({tag, " result after"}, result, exp_res);
  endtask

  initial begin
    int cyc;
    int n_done;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    last_exp = '0;
    step();
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    step();

    // Directed arithmetic cases.
    run_op("MUL 7*-3",       3'd0, 32'd7,        32'hFFFF_FFFD, 1'b0);
    run_op("MULH min*min",   3'd1, MIN_NEG,      MIN_NEG,       1'b0);
    run_op("MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("MULHSU -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,        1'b0);
    run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,        1'b0);
    run_op("DIVU 100/7",     3'd5, 32'd100,      32'd7,         1'b0);
    run_op("REMU 100/7",     3'd7, 32'd100,      32'd7,         1'b0);

    // Special cases finish the cycle after acceptance.
    run_op("DIV x/0",        3'd4, 32'h1234_5678, 32'h0,        1'b0);
    run_op("REMU 0x1234/0",  3'd7, 32'h0000_1234, 32'h0,        1'b0);
    run_op("DIV min/-1",     3'd4, MIN_NEG,      32'hFFFF_FFFF, 1'b0);
    run_op("REM min/-1",     3'd6, MIN_NEG,      32'hFFFF_FFFF, 1'b0);

    // start during calculation is ignored.
    run_op("MULHU poked",    3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    run_op("REM poked",      3'd6, 32'h8765_4321, 32'h0000_0FF1, 1'b1);

    // flush and start together in idle: nothing accepted.
    op = 3'd5; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", busy, 0);
    check("flush+start result", result, last_exp);

    // Flush a DIVU at N+10; the next op is started at N+11.
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    step();
    start  = 1'b0;
    cyc    = 1;
    n_done = 0;
    while (cyc < 10) begin
      if (done) n_done++;
      step();
      cyc++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush calc no done", n_done + int'(done), 0);
    check("flush calc busy", busy, 0);
    check("flush calc result", result, last_exp);
    run_op("DIVU after flush", 3'd5, 32'd1000, 32'd3, 1'b0);

    // Flush in the DONE cycle suppresses done and keeps the old result.
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 33) begin
      step();
      cyc++;
    end
    flush = 1'b1;
    #1;
    check("flush done pulse", done, 0);
    check("flush done result", result, last_exp);
    check("flush done busy", busy, 1);
    step();
    flush = 1'b0;
    check("flush done idle", busy, 0);
    check("flush done held", result, last_exp);

    // Reset at N+5 discards the operation.
    op = 3'd1; a = $urandom; b = $urandom; start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst result", result, 0);
    check("rst done", done, 0);
    n_done = 0;
    repeat (40) begin
      if (done) n_done++;
      step();
    end
    check("rst no late done", n_done, 0);
    last_exp = '0;

    // Random operations, back to back.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(),
             pick_operand(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
